// File: rtl/fp24_pkg.sv
// fp24 add/sub back end: shared field widths, constants and stage-1 payload type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp24_pkg;

    // Packed result layout: [23] sign, [22:15] exponent, [14:0] fraction.
    localparam int FP_WIDTH = 24;
    localparam int FP_EXPW  = 8;
    localparam int FP_FRACW = 15;

    // Front-end mantissa: [18] carry, [17] hidden, [16:2] fraction, [1] guard, [0] sticky.
    localparam int MANTW = FP_FRACW + 4;
    // Leading-zero window: hidden bit down to sticky.
    localparam int LZW   = FP_FRACW + 3;
    // Internal exponent is wider than the field and signed, so it never wraps.
    localparam int IEXPW = FP_EXPW + 2;

    localparam logic [FP_EXPW-1:0]  BIAS      = 8'd127;
    localparam logic [FP_EXPW-1:0]  EXP_MAX   = 8'd255;
    localparam logic [FP_WIDTH-1:0] CANON_NAN = 24'h7FC000;

    // out_flags_o = {overflow, underflow, inexact}
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    // Classification decided in stage 1; stage 2 only rounds KIND_NUM.
    typedef enum logic [1:0] {
        KIND_NUM  = 2'd0,
        KIND_ZERO = 2'd1,
        KIND_INF  = 2'd2,
        KIND_NAN  = 2'd3
    } kind_e;

    // Normalised operand handed from stage 1 to stage 2.
    // sig[15] is the hidden bit, sig[14:0] the fraction.
    typedef struct packed {
        logic                    sign;
        kind_e                   kind;
        logic signed [IEXPW-1:0] exp;
        logic [FP_FRACW:0]       sig;
        logic                    guard;
        logic                    sticky;
    } norm_t;

endpackage

// File: rtl/fp24_lzc.sv
// 18-bit leading-zero counter for the normalise stage; count = 18 for an all-zero input.
// Latency: combinational.
// Backpressure: none (pure function of value).
// Ports: value (18-bit word, MSB first), count (number of leading zeros, 0..18).
module fp24_lzc
    import fp24_pkg::*;
(
    input  logic [LZW-1:0] value,
    output logic [4:0]     count
);

    // Scan upward; the highest set bit is the last one to overwrite count.
    always_comb begin
        count = 5'd18;
        for (int i = 0; i < LZW; i++) begin
            if (value[i]) begin
                count = 5'(LZW - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp24_norm_round.sv
// fp24 add/sub back end: normalise, round-to-nearest-even, special values, pack to 24 bits.
// Latency: 2 cycles, 1 beat/cycle; a stage advances when its successor is empty or advancing.
// Backpressure: in_ready_o = !s1_valid || s2_advance (combinational from out_ready_i); outputs hold while stalled.
// Ports: clk_i/rst_i (sync, active-high); in_* beat from the align/add front end with
//        in_valid_i/in_ready_o; out_result_o/out_flags_o {ovf,unf,inx} with out_valid_o/out_ready_i.
module fp24_norm_round
    import fp24_pkg::*;
#(
    parameter int WIDTH = FP_WIDTH,
    parameter int EXPW  = FP_EXPW,
    parameter int FRACW = FP_FRACW
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             in_sign_i,
    input  logic [EXPW-1:0]  in_exp_i,
    input  logic [FRACW+3:0] in_mant_i,
    input  logic             in_nan_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_result_o,
    output logic [2:0]       out_flags_o
);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s2_advance;

    assign s2_advance  = !s2_valid || out_ready_i;
    assign in_ready_o  = !s1_valid || s2_advance;
    assign out_valid_o = s2_valid;

    // ------------------------------------------------------------------
    // Stage 1: classify and normalise
    // ------------------------------------------------------------------
    logic signed [IEXPW-1:0] exp_in;
    logic signed [IEXPW-1:0] shift_limit;
    logic [4:0]              lz;
    logic [4:0]              shamt;
    logic [LZW-1:0]          shifted;
    logic                    is_nan;
    logic                    is_inf;
    norm_t                   norm;
    norm_t                   s1;

    // A zero exponent field denotes a subnormal, which lives at exponent 1.
    assign exp_in = (in_exp_i == '0) ? 10'sd1 : $signed({2'b00, in_exp_i});

    fp24_lzc u_lzc (
        .value (in_mant_i[LZW-1:0]),
        .count (lz)
    );

    // Never shift the exponent below 1: anything left un-normalised
    // at that point is a subnormal.
    assign shift_limit = exp_in - 10'sd1;
    assign shamt       = ($signed({5'b0, lz}) <= shift_limit) ? lz : shift_limit[4:0];
    assign shifted     = in_mant_i[LZW-1:0] << shamt;

    assign is_nan = in_nan_i || ((in_exp_i == EXP_MAX) && (in_mant_i[16:2] != '0));
    assign is_inf = (in_exp_i == EXP_MAX);

    always_comb begin
        norm        = '0;
        norm.sign   = in_sign_i;
        norm.kind   = KIND_NUM;
        norm.exp    = exp_in;
        norm.sig    = in_mant_i[17:2];
        norm.guard  = in_mant_i[1];
        norm.sticky = in_mant_i[0];
        if (is_nan) begin
            norm.kind = KIND_NAN;
        end else if (is_inf) begin
            norm.kind = KIND_INF;
        end else if (in_mant_i == '0) begin
            norm.kind = KIND_ZERO;
        end else if (in_mant_i[18]) begin
            // Carry out of the adder: one step right, old guard and
            // sticky both fold into the new sticky.
            norm.exp    = exp_in + 10'sd1;
            norm.sig    = in_mant_i[18:3];
            norm.guard  = in_mant_i[2];
            norm.sticky = in_mant_i[1] | in_mant_i[0];
        end else begin
            norm.exp    = exp_in - $signed({5'b0, shamt});
            norm.sig    = shifted[17:2];
            norm.guard  = shifted[1];
            norm.sticky = shifted[0];
        end
    end

    // Payload carries no reset: it is only observed behind s1_valid.
    always_ff @(posedge clk_i) begin
        if (in_valid_i && in_ready_o) begin
            s1 <= norm;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round to nearest even, saturate, pack
    // ------------------------------------------------------------------
    logic                    round_up;
    logic                    inexact;
    logic [FP_FRACW+1:0]     rounded;
    logic signed [IEXPW-1:0] exp_r;
    logic                    hidden_r;
    logic [FP_WIDTH-1:0]     res_d;
    logic [2:0]              flg_d;

    assign round_up = s1.guard && (s1.sticky || s1.sig[0]);
    assign inexact  = s1.guard || s1.sticky;
    assign rounded  = {1'b0, s1.sig} + {16'b0, round_up};
    // A carry out of the significand leaves the fraction bits zero and bumps
    // the exponent; a subnormal that rounds up into the hidden bit sits at
    // exponent 1 already, so it packs with field 1 through the same path.
    assign exp_r    = s1.exp + $signed({9'b0, rounded[16]});
    assign hidden_r = rounded[16] || rounded[15];

    always_comb begin
        res_d = '0;
        flg_d = '0;
        case (s1.kind)
            KIND_NAN: begin
                res_d = CANON_NAN;
            end
            KIND_INF: begin
                res_d = {s1.sign, EXP_MAX, 15'b0};
            end
            KIND_ZERO: begin
                res_d = {s1.sign, 23'b0};
            end
            default: begin
                if (exp_r >= 10'sd255) begin
                    res_d           = {s1.sign, EXP_MAX, 15'b0};
                    flg_d[FLAG_OVF] = 1'b1;
                    flg_d[FLAG_INX] = 1'b1;
                end else begin
                    res_d           = {s1.sign, (hidden_r ? exp_r[7:0] : 8'd0), rounded[14:0]};
                    flg_d[FLAG_UNF] = !hidden_r && inexact;
                    flg_d[FLAG_INX] = inexact;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            out_result_o <= '0;
            out_flags_o  <= '0;
        end else begin
            if (in_ready_o) begin
                s1_valid <= in_valid_i;
            end
            if (s2_advance) begin
                s2_valid <= s1_valid;
            end
            // Output registers only change when a real beat moves in, so
            // they hold steady through a stall.
            if (s2_advance && s1_valid) begin
                out_result_o <= res_d;
                out_flags_o  <= flg_d;
            end
        end
    end

endmodule

// File: tb/tb_fp24_norm_round.sv
`timescale 1ns/1ps
module tb_fp24_norm_round;
    import fp24_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        in_sign_i;
    logic [7:0]  in_exp_i;
    logic [18:0] in_mant_i;
    logic        in_nan_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [23:0] out_result_o;
    logic [2:0]  out_flags_o;

    fp24_norm_round dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_sign_i    (in_sign_i),
        .in_exp_i     (in_exp_i),
        .in_mant_i    (in_mant_i),
        .in_nan_i     (in_nan_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_result_o (out_result_o),
        .out_flags_o  (out_flags_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [23:0] res;
        logic [2:0]  flg;
    } exp_t;

    exp_t sb[$];
    exp_t popped;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out    = 0;
    int   out_mark;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    // Scoreboard consumer: every output transfer must match the oldest expectation.
    always @(negedge clk_i) begin
        if (!rst_i && out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 32'(out_valid_o), 32'd0);
            end else begin
                popped = sb.pop_front();
                check({popped.name, ".res"}, 32'(out_result_o), 32'(popped.res));
                check({popped.name, ".flg"}, 32'(out_flags_o), 32'(popped.flg));
                n_out++;
            end
        end
    end

    // Drive one beat (entered just after a rising edge) and queue its expectation on acceptance.
    task automatic send(input string name, input logic s, input logic [7:0] e, input logic [18:0] m,
                        input logic nan, input logic [23:0] res, input logic [2:0] flg);
        int   waited = 0;
        exp_t item;
        in_valid_i = 1'b1;
        in_sign_i  = s;
        in_exp_i   = e;
        in_mant_i  = m;
        in_nan_i   = nan;
        @(negedge clk_i);
        while (!in_ready_o && waited < 50) begin
            waited++;
            @(negedge clk_i);
        end
        if (!in_ready_o) begin
            check({name, ".send_timeout"}, 32'(in_ready_o), 32'd1);
            in_valid_i = 1'b0;
        end else begin
            @(posedge clk_i);
            item.name = name;
            item.res  = res;
            item.flg  = flg;
            sb.push_back(item);
            #1 in_valid_i = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            waited++;
            @(negedge clk_i);
        end
        check({tag, ".pending"}, 32'(sb.size()), 32'd0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        in_sign_i   = 1'b0;
        in_exp_i    = '0;
        in_mant_i   = '0;
        in_nan_i    = 1'b0;
        out_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst.out_valid", 32'(out_valid_o), 32'd0);
        check("rst.result",    32'(out_result_o), 32'd0);
        check("rst.flags",     32'(out_flags_o), 32'd0);
        check("rst.in_ready",  32'(in_ready_o), 32'd1);
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Latency: accepted on edge P, visible after edge P+1.
        send("carry", 1'b0, BIAS, 19'h40000, 1'b0, 24'h400000, 3'b000);
        @(negedge clk_i);
        check("lat.cycle1", 32'(out_valid_o), 32'd0);
        @(negedge clk_i);
        check("lat.cycle2", 32'(out_valid_o), 32'd1);
        @(posedge clk_i);
        #1;

        // Directed vectors streamed back to back.
        send("cancel",       1'b0, 8'd130, 19'h04000, 1'b0, 24'h3F8000, 3'b000);
        send("rne_up",       1'b0, 8'd127, 19'h20006, 1'b0, 24'h3F8002, 3'b001);
        send("rne_even",     1'b0, 8'd127, 19'h20002, 1'b0, 24'h3F8000, 3'b001);
        send("ovf_carry",    1'b0, 8'd254, 19'h7FFFC, 1'b0, 24'h7F8000, 3'b101);
        send("nan_flag",     1'b0, 8'd100, 19'h20000, 1'b1, 24'h7FC000, 3'b000);
        send("sub_exact",    1'b0, 8'd1,   19'h00400, 1'b0, 24'h000100, 3'b000);
        send("sub_inexact",  1'b0, 8'd1,   19'h00402, 1'b0, 24'h000100, 3'b011);
        send("exp0_sub",     1'b1, 8'd0,   19'h00400, 1'b0, 24'h800100, 3'b000);
        send("sub_to_norm",  1'b0, 8'd1,   19'h1FFFE, 1'b0, 24'h008000, 3'b001);
        send("sub_limit",    1'b0, 8'd3,   19'h00400, 1'b0, 24'h000400, 3'b000);
        send("rnd_carry",    1'b0, 8'd127, 19'h3FFFE, 1'b0, 24'h400000, 3'b001);
        send("rnd_ovf",      1'b1, 8'd254, 19'h3FFFE, 1'b0, 24'hFF8000, 3'b101);
        send("inf_pass",     1'b1, 8'd255, 19'h00000, 1'b0, 24'hFF8000, 3'b000);
        send("nan_frac",     1'b0, 8'd255, 19'h00004, 1'b0, 24'h7FC000, 3'b000);
        send("zero_neg",     1'b1, 8'd100, 19'h00000, 1'b0, 24'h800000, 3'b000);
        send("carry_sticky", 1'b0, 8'd127, 19'h40002, 1'b0, 24'h400000, 3'b001);
        send("neg_one",      1'b1, 8'd127, 19'h20000, 1'b0, 24'hBF8000, 3'b000);
        drain("stream");

        // Backpressure: consumer stalls 3 cycles while two beats fill the pipe.
        out_mark    = n_out;
        out_ready_i = 1'b0;
        send("bp0", 1'b0, 8'd127, 19'h20000, 1'b0, 24'h3F8000, 3'b000);
        send("bp1", 1'b0, 8'd128, 19'h20000, 1'b0, 24'h400000, 3'b000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("bp.in_ready",  32'(in_ready_o), 32'd0);
            check("bp.out_valid", 32'(out_valid_o), 32'd1);
            check("bp.hold_res",  32'(out_result_o), 32'h3F8000);
            check("bp.hold_flg",  32'(out_flags_o), 32'd0);
        end
        @(posedge clk_i);
        #1 out_ready_i = 1'b1;
        send("bp2", 1'b0, 8'd128, 19'h30000, 1'b0, 24'h404000, 3'b000);
        send("bp3", 1'b1, 8'd127, 19'h30000, 1'b0, 24'hBFC000, 3'b000);
        drain("bp");
        check("bp.count", 32'(n_out - out_mark), 32'd4);

        // Reset while stalled drops both buffered beats.
        out_ready_i = 1'b0;
        send("rs0", 1'b0, 8'd127, 19'h20000, 1'b0, 24'h3F8000, 3'b000);
        send("rs1", 1'b0, 8'd128, 19'h20000, 1'b0, 24'h400000, 3'b000);
        @(negedge clk_i);
        check("rs.stall_rdy", 32'(in_ready_o), 32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        sb.delete();
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        out_ready_i = 1'b1;
        out_mark    = n_out;
        @(negedge clk_i);
        check("rs.out_valid", 32'(out_valid_o), 32'd0);
        check("rs.result",    32'(out_result_o), 32'd0);
        check("rs.flags",     32'(out_flags_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("rs.no_stale", 32'(out_valid_o), 32'd0);
        end
        @(posedge clk_i);
        #1;
        send("post_rst", 1'b0, 8'd129, 19'h20000, 1'b0, 24'h408000, 3'b000);
        drain("post_rst");
        check("rs.count", 32'(n_out - out_mark), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
